// File: rtl/uart_seg_pkg.sv
// Shared types and seven-segment glyph tables for the UART-to-display path.
// All glyphs are active-low, bit order {dp,g,f,e,d,c,b,a}.
package uart_seg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BAD   = 8'h7F;

  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  // Letters 'A'-'F' and 'a'-'f' have low nibbles 1-6, so +9 maps them to 10-15.
  function automatic logic [7:0] ascii_to_seg(input logic [7:0] ch);
    if (ch >= 8'h30 && ch <= 8'h39)
      return hex_seg(ch[3:0]);
    else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66))
      return hex_seg(ch[3:0] + 4'd9);
    else if (ch == 8'h2D)
      return SEG_DASH;
    else if (ch == 8'h20)
      return SEG_BLANK;
    else
      return SEG_BAD;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: input synchroniser, framing FSM and shift register.
// valid/frame_err are single-cycle strobes on the stop-bit sample.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | line idle, waiting for a synced falling edge
// ST_START | counting to mid start bit to reject glitches
// ST_DATA  | sampling 8 data bits LSB first, one per bit time
// ST_STOP  | waiting for mid stop bit, accept or flag framing error
// ST_BREAK | line held low after a framing error, wait for high
module uart_rx_core
  import uart_seg_pkg::*;
#(
  parameter int CPB = 1250
) (
  input  logic       clk_12mhz,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  logic             rx_meta;
  logic             rxs;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift;

  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rxs) state <= ST_START;
        end
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rxs ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shift <= {rxs, shift[7:1]};
            idx   <= idx + 1'b1;
            if (idx == 3'd7) state <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= rxs ? ST_IDLE : ST_BREAK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          cnt <= '0;
          if (rxs) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign data      = shift;
  assign valid     = (state == ST_STOP) && (cnt == CNT_LAST) && rxs;
  assign frame_err = (state == ST_STOP) && (cnt == CNT_LAST) && !rxs;
  assign busy      = (state != ST_IDLE);

endmodule

// File: rtl/uart_rx_seg.sv
// UART receiver driving the common-anode seven-segment pins and status LEDs.
// Display, data and error flag all register on the same edge as rx_valid.
module uart_rx_seg
  import uart_seg_pkg::*;
#(
  parameter int CLK_HZ   = 12000000,
  parameter int BAUD     = 9600,
  parameter int LED_HOLD = 1200000
) (
  input  logic       clk_12mhz,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [7:0] seg_pins,
  output logic       led_green,
  output logic       led_red,
  output logic       led_blue
);

  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HOLD_W = $clog2(LED_HOLD + 1);

  logic [7:0]        core_data;
  logic              core_valid;
  logic              core_err;
  logic              core_busy;
  logic [HOLD_W-1:0] hold_cnt;

  uart_rx_core #(
    .CPB(CPB)
  ) u_core (
    .clk_12mhz (clk_12mhz),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .data      (core_data),
    .valid     (core_valid),
    .frame_err (core_err),
    .busy      (core_busy)
  );

  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      seg_pins <= SEG_BLANK;
      led_red  <= 1'b0;
    end else begin
      rx_valid <= core_valid;
      if (core_valid) begin
        rx_data  <= core_data;
        seg_pins <= ascii_to_seg(core_data);
        led_red  <= 1'b0;
      end else if (core_err) begin
        led_red  <= 1'b1;
      end
    end
  end

  // Activity stretch; a new byte restarts the full hold period.
  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst)
      hold_cnt <= '0;
    else if (rx_valid)
      hold_cnt <= HOLD_W'(LED_HOLD);
    else if (hold_cnt != '0)
      hold_cnt <= hold_cnt - 1'b1;
  end

  assign led_green = (hold_cnt != '0);
  assign led_blue  = core_busy;

endmodule

// File: tb/tb_uart_rx_seg.sv
// Randomised bench for uart_rx_seg against a byte-level reference model.
module tb_uart_rx_seg;

  localparam int CLK_HZ   = 12000000;
  localparam int BAUD     = 1000000;
  localparam int LED_HOLD = 100;
  localparam int CPB      = CLK_HZ / BAUD;
  localparam int HALF     = CPB / 2;

  logic       clk_12mhz = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] seg_pins;
  logic       led_green;
  logic       led_red;
  logic       led_blue;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int green_cnt = 0;
  int blue_cnt  = 0;
  logic [7:0] got_q[$];
  int         pulse_cyc[$];
  logic [7:0] exp_q[$];

  uart_rx_seg #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .LED_HOLD (LED_HOLD)
  ) dut (
    .clk_12mhz (clk_12mhz),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .seg_pins  (seg_pins),
    .led_green (led_green),
    .led_red   (led_red),
    .led_blue  (led_blue)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  always @(posedge clk_12mhz) cyc <= cyc + 1;

  always @(negedge clk_12mhz) begin
    if (rx_valid) begin
      got_q.push_back(rx_data);
      pulse_cyc.push_back(cyc);
    end
    if (led_green) green_cnt++;
    if (led_blue)  blue_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference display glyph: value of the hex character, then glyph lookup.
  function automatic logic [7:0] model_seg(input logic [7:0] c);
    logic [7:0] glyph [16];
    int v;
    glyph = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    v = -1;
    if (c >= "0" && c <= "9") v = int'(c) - int'("0");
    if (c >= "A" && c <= "F") v = int'(c) - int'("A") + 10;
    if (c >= "a" && c <= "f") v = int'(c) - int'("a") + 10;
    if (v >= 0) return glyph[v];
    if (c == "-") return 8'hBF;
    if (c == " ") return 8'hFF;
    return 8'h7F;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_b);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk_12mhz);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk_12mhz);
    end
    uart_rx = stop_b;
    repeat (CPB) @(negedge clk_12mhz);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, g0, b0, nb;
    logic [7:0] b;
    logic [7:0] last_seg;

    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk_12mhz);
    check("rst_seg", seg_pins, 8'hFF);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_leds", {led_green, led_red, led_blue}, 3'b000);

    // Reset in the middle of a frame
    rst = 1'b0;
    repeat (4) @(negedge clk_12mhz);
    n0 = got_q.size();
    uart_rx = 1'b0; repeat (CPB) @(negedge clk_12mhz);
    uart_rx = 1'b1; repeat (CPB) @(negedge clk_12mhz);
    uart_rx = 1'b0; repeat (2 * CPB) @(negedge clk_12mhz);
    check("midframe_busy", led_blue, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_seg", seg_pins, 8'hFF);
    check("midrst_leds", {led_green, led_red, led_blue}, 3'b000);
    check("midrst_valid", rx_valid, 1'b0);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk_12mhz);
    rst = 1'b0;
    repeat (20 * CPB) @(negedge clk_12mhz);
    check("midrst_no_pulse", got_q.size() - n0, 0);

    // Single byte '5'
    n0 = got_q.size(); g0 = green_cnt; b0 = blue_cnt;
    send_byte(8'h35, 1'b1);
    repeat (2) @(negedge clk_12mhz);
    check("b35_seg", seg_pins, model_seg(8'h35));
    check("b35_data", rx_data, 8'h35);
    check("b35_blue_len", blue_cnt - b0, HALF + 9 * CPB);
    repeat (LED_HOLD + 20) @(negedge clk_12mhz);
    check("b35_pulses", got_q.size() - n0, 1);
    check("b35_green_len", green_cnt - g0, LED_HOLD);
    check("b35_idle_leds", {led_green, led_blue}, 2'b00);

    // 'a' then 'Z'
    n0 = got_q.size();
    send_byte("a", 1'b1);
    repeat (2) @(negedge clk_12mhz);
    check("a_seg", seg_pins, model_seg("a"));
    send_byte("Z", 1'b1);
    repeat (2) @(negedge clk_12mhz);
    check("Z_seg", seg_pins, model_seg("Z"));
    check("aZ_pulses", got_q.size() - n0, 2);
    check("aZ_data", rx_data, 8'h5A);

    // Short glitch on the line
    n0 = got_q.size();
    uart_rx = 1'b0; repeat (3) @(negedge clk_12mhz);
    uart_rx = 1'b1; repeat (3 * CPB) @(negedge clk_12mhz);
    check("glitch_pulses", got_q.size() - n0, 0);
    check("glitch_seg", seg_pins, model_seg("Z"));
    check("glitch_busy", led_blue, 1'b0);

    // Framing error and held-low line
    n0 = got_q.size();
    send_byte(8'h41, 1'b0);
    repeat (3 * CPB) @(negedge clk_12mhz);
    check("ferr_red", led_red, 1'b1);
    check("ferr_break_busy", led_blue, 1'b1);
    check("ferr_pulses", got_q.size() - n0, 0);
    check("ferr_seg", seg_pins, model_seg("Z"));
    uart_rx = 1'b1;
    repeat (6) @(negedge clk_12mhz);
    check("ferr_released", {led_red, led_blue}, 2'b10);
    send_byte("0", 1'b1);
    repeat (2) @(negedge clk_12mhz);
    check("ferr_clear_red", led_red, 1'b0);
    check("ferr_0_seg", seg_pins, model_seg("0"));

    // Back-to-back "12"
    n0 = got_q.size();
    send_byte("1", 1'b1);
    send_byte("2", 1'b1);
    repeat (2) @(negedge clk_12mhz);
    check("b2b_pulses", got_q.size() - n0, 2);
    if (got_q.size() - n0 == 2)
      check("b2b_spacing", pulse_cyc[n0 + 1] - pulse_cyc[n0], 10 * CPB);
    check("b2b_seg", seg_pins, model_seg("2"));
    check("b2b_data", rx_data, "2");

    // Random bytes with random idle gaps
    n0 = got_q.size();
    last_seg = seg_pins;
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 3))
        0: b = 8'("0" + $urandom_range(0, 9));
        1: b = 8'(($urandom_range(0, 1) ? "a" : "A") + $urandom_range(0, 5));
        2: b = $urandom_range(0, 1) ? 8'h2D : 8'h20;
        default: b = 8'($urandom_range(0, 255));
      endcase
      exp_q.push_back(b);
      uart_rx = 1'b1;
      repeat ($urandom_range(0, 2 * CPB)) @(negedge clk_12mhz);
      send_byte(b, 1'b1);
      repeat (2) @(negedge clk_12mhz);
      last_seg = model_seg(b);
      check($sformatf("rand_seg_%0d", i), seg_pins, last_seg);
    end
    nb = got_q.size() - n0;
    check("rand_pulses", nb, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < nb; i++)
      check($sformatf("rand_data_%0d", i), got_q[n0 + i], exp_q[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
